scroll_step_gen: RTL and testbench

Clean step-enable generator upstream of the scrolling display's state machine. It runs on the 50 MHz board clock and debounces two raw push-buttons. It emits single-cycle `step` pulses, either one per manual press or periodically in auto-scroll mode. The display logic then advances on `step` as a synchronous enable instead of using a push-button as its clock.

---
 rtl/scroll_pkg.sv | 17 +
 rtl/key_debouncer.sv | 87 ++++++++
 rtl/scroll_step_gen.sv | 72 +++++++
 tb/tb_scroll_step_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared types and default timing constants for the scroll step generator.
package scroll_pkg;

  // Debouncer states; PRESSED and RELEASE_WAIT both report the button as held.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  // 20 ms at 50 MHz
  localparam int unsigned DEBOUNCE_DEFAULT    = 1_000_000;
  // 0.5 s at 50 MHz
  localparam int unsigned AUTO_PERIOD_DEFAULT = 25_000_000;

endpackage : scroll_pkg

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus debounce FSM for one active-low push-button.
module key_debouncer
  import scroll_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic resetb,
  input  logic btn_n,
  output logic level,
  output logic press_evt
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;

  // Bring the raw button into the clock domain; idle level is released (1).
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], btn_n};
  end

  assign btn_s = sync_q[1];

  // State, counter and debounced level registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
    end
  end

  // Next state; the press event is a decode of the accepting transition so the
  // top-level step register can capture it on the same edge the FSM enters PRESSED.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (!btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (btn_s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

endmodule : key_debouncer

// File: rtl/scroll_step_gen.sv
// Turns two raw buttons into clean single-cycle step pulses, manual or auto-scrolled.
module scroll_step_gen
  import scroll_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEFAULT
) (
  input  logic clock,
  input  logic resetb,
  input  logic key_n,
  input  logic mode_n,
  output logic step,
  output logic auto_on,
  output logic pressed
);

  localparam int unsigned       TMR_W    = $clog2(AUTO_PERIOD);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  logic             key_evt;
  logic             mode_evt;
  logic             mode_level_unused;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tick_c;
  logic             auto_on_d;
  logic             step_d;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clock     (clock),
    .resetb    (resetb),
    .btn_n     (key_n),
    .level     (pressed),
    .press_evt (key_evt)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock     (clock),
    .resetb    (resetb),
    .btn_n     (mode_n),
    .level     (mode_level_unused),
    .press_evt (mode_evt)
  );

  // Mode flop, auto timer and step pulse register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      auto_on <= 1'b0;
      tmr_q   <= '0;
      step    <= 1'b0;
    end else begin
      auto_on <= auto_on_d;
      tmr_q   <= tmr_d;
      step    <= step_d;
    end
  end

  // Timer holds at 0 in manual mode; a manual press restarts the period.
  // A tick coinciding with the toggle-off press is dropped.
  always_comb begin
    tick_c    = 1'b0;
    auto_on_d = auto_on ^ mode_evt;
    tmr_d     = '0;
    step_d    = key_evt;
    if (auto_on) begin
      tick_c = (tmr_q == TMR_LAST);
      if (key_evt || tick_c) tmr_d = '0;
      else                   tmr_d = tmr_q + TMR_W'(1);
    end
    if (tick_c && !mode_evt) step_d = 1'b1;
  end

endmodule : scroll_step_gen

// File: tb/tb_scroll_step_gen.sv
// Directed bench for scroll_step_gen with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
module tb_scroll_step_gen;

  logic clock;
  logic resetb;
  logic key_n;
  logic mode_n;
  logic step;
  logic auto_on;
  logic pressed;

  int checks = 0;
  int errors = 0;
  int pulses;

  scroll_step_gen #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
    .clock   (clock),
    .resetb  (resetb),
    .key_n   (key_n),
    .mode_n  (mode_n),
    .step    (step),
    .auto_on (auto_on),
    .pressed (pressed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges, counting step pulses seen.
  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (step === 1'b1) p++;
    end
  endtask

  initial begin
    resetb = 1'b0;
    key_n  = 1'b1;
    mode_n = 1'b1;
    ticks(3);
    chk("rst_step", int'(step), 0);
    chk("rst_auto", int'(auto_on), 0);
    chk("rst_pressed", int'(pressed), 0);
    resetb = 1'b1;
    count_pulses(5, pulses);
    chk("idle_pulses", pulses, 0);

    // Clean press: step only after edge 7, one pulse over 50 cycles.
    key_n = 1'b0;
    count_pulses(6, pulses);
    chk("press_early", pulses, 0);
    chk("press_pressed_early", int'(pressed), 0);
    tick();
    chk("press_step", int'(step), 1);
    chk("press_pressed", int'(pressed), 1);
    tick();
    chk("press_step_off", int'(step), 0);
    count_pulses(42, pulses);
    chk("press_no_repeat", pulses, 0);
    chk("press_held", int'(pressed), 1);

    // Release: pressed falls after edge 7.
    key_n = 1'b1;
    ticks(6);
    chk("release_early", int'(pressed), 1);
    tick();
    chk("release_pressed", int'(pressed), 0);
    ticks(3);

    // Bounce: 2-cycle low/high segments, then settle low.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 2; j++) begin
        tick();
        if (step === 1'b1) pulses++;
      end
    end
    chk("bounce_pulses", pulses, 0);
    key_n = 1'b0;
    count_pulses(6, pulses);
    chk("bounce_settle_early", pulses, 0);
    tick();
    chk("bounce_step", int'(step), 1);
    count_pulses(5, pulses);
    chk("bounce_single", pulses, 0);
    key_n = 1'b1;
    ticks(10);
    chk("bounce_released", int'(pressed), 0);

    // Auto mode: toggle at edge T (7th edge of the mode press).
    mode_n = 1'b0;
    ticks(6);
    chk("mode_early", int'(auto_on), 0);
    tick();                                   // T
    chk("mode_on", int'(auto_on), 1);
    chk("mode_no_step", int'(step), 0);
    mode_n = 1'b1;
    count_pulses(7, pulses);                  // T+1..T+7
    chk("auto_first_early", pulses, 0);
    tick();                                   // T+8
    chk("auto_first", int'(step), 1);
    count_pulses(7, pulses);                  // T+9..T+15
    chk("auto_gap1", pulses, 0);
    key_n = 1'b0;                             // key press event lands on T+22
    tick();                                   // T+16
    chk("auto_second", int'(step), 1);
    count_pulses(5, pulses);                  // T+17..T+21
    chk("manual_early", pulses, 0);
    tick();                                   // T+22, timer was at 5
    chk("manual_step", int'(step), 1);
    key_n = 1'b1;
    count_pulses(7, pulses);                  // T+23..T+29
    chk("manual_restart_gap", pulses, 0);
    tick();                                   // T+30
    chk("auto_after_manual", int'(step), 1);
    tick();                                   // T+31
    chk("auto_still_on", int'(auto_on), 1);

    // Simultaneous: key press event aligned with the T+38 tick.
    key_n = 1'b0;
    count_pulses(6, pulses);                  // T+32..T+37
    chk("sim_early", pulses, 0);
    tick();                                   // T+38
    chk("sim_step", int'(step), 1);
    key_n = 1'b1;
    tick();                                   // T+39
    chk("sim_single", int'(step), 0);
    count_pulses(6, pulses);                  // T+40..T+45
    chk("sim_gap", pulses, 0);
    tick();                                   // T+46
    chk("sim_next_tick", int'(step), 1);

    // Toggle off on the T+54 tick.
    tick();                                   // T+47
    mode_n = 1'b0;
    count_pulses(6, pulses);                  // T+48..T+53
    chk("off_early", pulses, 0);
    chk("off_still_on", int'(auto_on), 1);
    tick();                                   // T+54
    chk("off_auto", int'(auto_on), 0);
    chk("off_step_suppressed", int'(step), 0);
    mode_n = 1'b1;
    count_pulses(30, pulses);
    chk("off_no_pulses", pulses, 0);

    // Reset mid-press, then key still held across reset release.
    key_n = 1'b0;
    ticks(5);
    resetb = 1'b0;
    #1;
    chk("midrst_step", int'(step), 0);
    chk("midrst_pressed", int'(pressed), 0);
    chk("midrst_auto", int'(auto_on), 0);
    ticks(3);
    resetb = 1'b1;
    count_pulses(6, pulses);
    chk("postrst_early", pulses, 0);
    tick();
    chk("postrst_step", int'(step), 1);
    chk("postrst_pressed", int'(pressed), 1);
    count_pulses(20, pulses);
    chk("postrst_single", pulses, 0);
    key_n = 1'b1;
    ticks(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_scroll_step_gen
